// File: rtl/fpga_rst_seq.sv
// fpga_rst_seq: reset sequencer between clock wizard and SoC core.
// Syncs (and optionally debounces) the button, waits for stable PLL lock,
// then releases NUM_CH active-low resets one per GAP_CYCLES; records cause.
// Ports: clk_i, rst_i (sync, active-high), ext_rst_n_i, pll_locked_i,
//        sw_rst_req_i -> rst_n_o[NUM_CH], seq_done_o, rst_cause_o, state_o.
// Optional macro RST_SEQ_DEBOUNCE_EN enables the DEB_CYCLES button filter.
module fpga_rst_seq #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned GAP_CYCLES = 256,
    parameter int unsigned LOCK_WAIT  = 1024,
    parameter int unsigned DEB_CYCLES = 50000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ext_rst_n_i,
    input  logic              pll_locked_i,
    input  logic              sw_rst_req_i,
    output logic [NUM_CH-1:0] rst_n_o,
    output logic              seq_done_o,
    output logic [1:0]        rst_cause_o,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        S_HOLD      = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_RELEASE   = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    localparam logic [1:0] C_BTN  = 2'd1;
    localparam logic [1:0] C_LOCK = 2'd2;
    localparam logic [1:0] C_SW   = 2'd3;

    localparam int LW = $clog2(LOCK_WAIT) + 1;
    localparam int GW = $clog2(GAP_CYCLES) + 1;
    localparam int IW = $clog2(NUM_CH) + 1;

    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_WAIT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_CH - 1);

    // Two-flop synchronisers
    logic btn_meta_q, btn_s_q;
    logic lock_meta_q, lock_s_q;
    logic btn_f;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_meta_q  <= 1'b1;
            btn_s_q     <= 1'b1;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            btn_meta_q  <= ext_rst_n_i;
            btn_s_q     <= btn_meta_q;
            lock_meta_q <= pll_locked_i;
            lock_s_q    <= lock_meta_q;
        end
    end

`ifdef RST_SEQ_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYCLES) + 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          btn_f_q, btn_f_d;

    // Flip only after DEB_CYCLES consecutive mismatching cycles
    always_comb begin
        btn_f_d   = btn_f_q;
        deb_cnt_d = '0;
        if (btn_s_q != btn_f_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                btn_f_d = btn_s_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_f_q   <= 1'b1;
            deb_cnt_q <= '0;
        end else begin
            btn_f_q   <= btn_f_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign btn_f = btn_f_q;
`else
    assign btn_f = btn_s_q;
`endif

    state_t            state_q, state_d;
    logic [LW-1:0]     lock_cnt_q, lock_cnt_d;
    logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [NUM_CH-1:0] rst_n_q, rst_n_d;
    logic              done_q, done_d;
    logic [1:0]        cause_q, cause_d;
    logic              hold_req;
    logic [1:0]        hold_cause;

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        idx_d      = idx_q;
        rst_n_d    = rst_n_q;
        done_d     = done_q;
        cause_d    = cause_q;
        hold_req   = 1'b0;
        hold_cause = C_BTN;

        unique case (state_q)
            S_HOLD: begin
                rst_n_d    = '0;
                done_d     = 1'b0;
                lock_cnt_d = '0;
                gap_cnt_d  = '0;
                idx_d      = '0;
                if (btn_f) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (!btn_f) begin
                    hold_req = 1'b1;
                end else if (!lock_s_q) begin
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    state_d    = S_RELEASE;
                    lock_cnt_d = '0;
                    gap_cnt_d  = '0;
                    idx_d      = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + LW'(1);
                end
            end
            S_RELEASE: begin
                if (!btn_f) begin
                    hold_req = 1'b1;
                end else if (!lock_s_q) begin
                    hold_req   = 1'b1;
                    hold_cause = C_LOCK;
                end else if (gap_cnt_q == GAP_LAST) begin
                    // Channels release in index order, so shift in a one
                    gap_cnt_d = '0;
                    rst_n_d   = (rst_n_q << 1) | NUM_CH'(1);
                    idx_d     = idx_q + IW'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = S_RUN;
                        done_d  = 1'b1;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            S_RUN: begin
                if (!btn_f) begin
                    hold_req = 1'b1;
                end else if (!lock_s_q) begin
                    hold_req   = 1'b1;
                    hold_cause = C_LOCK;
                end else if (sw_rst_req_i) begin
                    hold_req   = 1'b1;
                    hold_cause = C_SW;
                end
            end
        endcase

        if (hold_req) begin
            state_d    = S_HOLD;
            rst_n_d    = '0;
            done_d     = 1'b0;
            cause_d    = hold_cause;
            lock_cnt_d = '0;
            gap_cnt_d  = '0;
            idx_d      = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_HOLD;
            lock_cnt_q <= '0;
            gap_cnt_q  <= '0;
            idx_q      <= '0;
            rst_n_q    <= '0;
            done_q     <= 1'b0;
            cause_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            idx_q      <= idx_d;
            rst_n_q    <= rst_n_d;
            done_q     <= done_d;
            cause_q    <= cause_d;
        end
    end

    assign rst_n_o     = rst_n_q;
    assign seq_done_o  = done_q;
    assign rst_cause_o = cause_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_fpga_rst_seq.sv
// tb_fpga_rst_seq: directed + random checks of fpga_rst_seq against a
// cycle-count reference model (consecutive-lock and elapsed-time arithmetic).
module tb_fpga_rst_seq;

    localparam int NUM_CH = 4;
    localparam int GAP    = 4;
    localparam int LOCKW  = 8;
    localparam int DEB    = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              btn = 1'b1;
    logic              lock = 1'b1;
    logic              sw = 1'b0;
    logic [NUM_CH-1:0] rst_n_o;
    logic              seq_done_o;
    logic [1:0]        rst_cause_o;
    logic [1:0]        state_o;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state
    int m_phase = 0;
    int m_cause = 0;
    int m_locked = 0;
    int m_elapsed = 0;
    int m_deb = 0;
    bit m_bp1 = 1, m_bs = 1, m_lp1 = 0, m_ls = 0, m_bf = 1;

    fpga_rst_seq #(
        .NUM_CH    (NUM_CH),
        .GAP_CYCLES(GAP),
        .LOCK_WAIT (LOCKW),
        .DEB_CYCLES(DEB)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ext_rst_n_i (btn),
        .pll_locked_i(lock),
        .sw_rst_req_i(sw),
        .rst_n_o     (rst_n_o),
        .seq_done_o  (seq_done_o),
        .rst_cause_o (rst_cause_o),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(string tag);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired, observed none expected event", tag);
    endtask

    task automatic go_hold(int c);
        m_phase  = 0;
        m_cause  = c;
        m_locked = 0;
    endtask

    task automatic model_step();
        bit bs, ls, bf;
        if (rst) begin
            m_phase = 0; m_cause = 0; m_locked = 0; m_elapsed = 0;
            m_bp1 = 1; m_bs = 1; m_lp1 = 0; m_ls = 0; m_bf = 1; m_deb = 0;
            return;
        end
        bs = m_bs; ls = m_ls; bf = m_bf;
        case (m_phase)
            0: if (bf) begin m_phase = 1; m_locked = 0; end
            1: begin
                if (!bf) go_hold(1);
                else if (ls) begin
                    m_locked++;
                    if (m_locked == LOCKW) begin m_phase = 2; m_elapsed = 0; end
                end else m_locked = 0;
            end
            2: begin
                if (!bf) go_hold(1);
                else if (!ls) go_hold(2);
                else begin
                    m_elapsed++;
                    if (m_elapsed == GAP * NUM_CH) m_phase = 3;
                end
            end
            default: begin
                if (!bf) go_hold(1);
                else if (!ls) go_hold(2);
                else if (sw) go_hold(3);
            end
        endcase
        m_bs = m_bp1; m_bp1 = btn;
        m_ls = m_lp1; m_lp1 = lock;
`ifdef RST_SEQ_DEBOUNCE_EN
        if (bs != bf) begin
            m_deb++;
            if (m_deb == DEB) begin m_bf = bs; m_deb = 0; end
        end else m_deb = 0;
`else
        m_bf = m_bs;
`endif
    endtask

    function automatic logic [63:0] exp_mask();
        logic [63:0] one = 64'd1;
        if (m_phase == 3) return (one << NUM_CH) - one;
        if (m_phase == 2) return (one << (m_elapsed / GAP)) - one;
        return 64'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("rst_n", 64'(rst_n_o), exp_mask());
        check("done", 64'(seq_done_o), 64'(m_phase == 3));
        check("cause", 64'(rst_cause_o), 64'(m_cause));
        check("state", 64'(state_o), 64'(m_phase));
    endtask

    task automatic wait_phase(int ph, int bound, string tag);
        int k = 0;
        while (m_phase != ph && k < bound) begin tick(); k++; end
        if (m_phase != ph) timeout(tag);
    endtask

    initial begin
        int n;
        int lk_left, bt_left;
        // Power-up
        repeat (5) tick();
        rst = 1'b0;
        wait_phase(3, 100, "powerup");
        check("pu_rst_n", 64'(rst_n_o), 64'hF);
        check("pu_cause", 64'(rst_cause_o), 64'd0);

        // Lock glitch during WAIT_LOCK
        rst = 1'b1; tick(); rst = 1'b0;
        n = 0;
        while (m_locked != 5 && n < 50) begin tick(); n++; end
        if (m_locked != 5) timeout("glitch_arm");
        lock = 1'b0; tick(); lock = 1'b1;
        n = 0;
        while (state_o != 2'd2 && n < 40) begin tick(); n++; end
        check("glitch_lat", 64'(n), 64'd10);
        wait_phase(3, 100, "glitch_run");

        // Lock loss in RUN
        lock = 1'b0;
        n = 0;
        while (rst_n_o != '0 && n < 10) begin tick(); n++; end
        check("lockloss_lat", 64'(n), 64'd3);
        check("lockloss_cause", 64'(rst_cause_o), 64'd2);
        repeat (3) tick();
        lock = 1'b1;
        wait_phase(3, 100, "lockloss_run");
        check("lockloss_rst_n", 64'(rst_n_o), 64'hF);

        // Software request in RUN, then ignored in RELEASE
        sw = 1'b1; tick(); sw = 1'b0;
        check("sw_state", 64'(state_o), 64'd0);
        check("sw_cause", 64'(rst_cause_o), 64'd3);
        wait_phase(2, 100, "sw_rel");
        repeat (5) tick();
        sw = 1'b1; tick(); sw = 1'b0;
        check("sw_rel_state", 64'(state_o), 64'd2);
        wait_phase(3, 100, "sw_run");

        // Button pulses
`ifdef RST_SEQ_DEBOUNCE_EN
        btn = 1'b0; repeat (10) tick(); btn = 1'b1;
        repeat (30) tick();
        check("btn10_state", 64'(state_o), 64'd3);
        btn = 1'b0; repeat (20) tick(); btn = 1'b1;
        check("btn20_state", 64'(state_o), 64'd0);
        check("btn20_cause", 64'(rst_cause_o), 64'd1);
`else
        btn = 1'b0; repeat (3) tick(); btn = 1'b1;
        check("btn3_state", 64'(state_o), 64'd0);
        check("btn3_cause", 64'(rst_cause_o), 64'd1);
`endif

        // rst_i mid-RELEASE after 0011
        n = 0;
        while (!(m_phase == 2 && m_elapsed / GAP == 2) && n < 200) begin
            tick(); n++;
        end
        if (!(m_phase == 2 && m_elapsed / GAP == 2)) timeout("midrel");
        check("midrel_pre", 64'(rst_n_o), 64'h3);
        rst = 1'b1; tick();
        check("midrel_rst_n", 64'(rst_n_o), 64'h0);
        check("midrel_state", 64'(state_o), 64'd0);
        check("midrel_cause", 64'(rst_cause_o), 64'd0);
        rst = 1'b0;

        // Randomised traffic
        lk_left = 0; bt_left = 0;
        for (int i = 0; i < 4000; i++) begin
            lock = (lk_left == 0);
            if (lk_left > 0) lk_left--;
            else if ($urandom_range(0, 299) == 0) lk_left = $urandom_range(1, 4);
            btn = (bt_left == 0);
            if (bt_left > 0) bt_left--;
            else if ($urandom_range(0, 399) == 0) bt_left = $urandom_range(1, 30);
            sw  = ($urandom_range(0, 49) == 0);
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 1'b0; sw = 1'b0; btn = 1'b1; lock = 1'b1;
        wait_phase(3, 200, "final_run");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fpga_rst_seq.md
# fpga_rst_seq

Parametrised reset sequencer for the FPGA tops. Sits between the clock wizard and the SoC core. Synchronises and debounces the board reset button, waits for a stable PLL lock, then releases NUM_CH active-low reset channels one at a time with a fixed gap. Re-sequences on button press, lock loss or a software request, and records the cause of the last reset.

## Interface
- NUM_CH, 4: number of sequenced reset channels (1..32)
- GAP_CYCLES, 256: cycles between successive channel releases (>=1)
- LOCK_WAIT, 1024: consecutive locked cycles required before release (>=1)
- DEB_CYCLES, 50000: button stability window in cycles (>=1; used only with RST_SEQ_DEBOUNCE_EN)
- clk_i  in  1  single clock (clock-wizard output)
- rst_i  in  1  reset; synchronous, active-high
- ext_rst_n_i  in  1  board button, asynchronous, active-low
- pll_locked_i  in  1  clock-wizard lock, asynchronous
- sw_rst_req_i  in  1  one-cycle pulse from SoC requesting full re-sequence
- rst_n_o  out  NUM_CH  channel resets, active-low; bit k released k-th
- seq_done_o  out  1  high in RUN
- rst_cause_o  out  2  last cause: 0 POR/rst_i, 1 button, 2 lock loss, 3 software
- state_o  out  2  FSM state: 0 HOLD, 1 WAIT_LOCK, 2 RELEASE, 3 RUN

## Operation
- ext_rst_n_i and pll_locked_i each pass through a 2-flop synchroniser; btn_s and lock_s are the synchronised values.
- btn_f: filtered button (see Configuration). Button asserted means btn_f==0.
- HOLD: rst_n_o all 0, seq_done_o 0. Stay while btn_f==0; otherwise -> WAIT_LOCK. Minimum one cycle in HOLD.
- WAIT_LOCK: lock_cnt increments while lock_s==1, clears to 0 when lock_s==0. When lock_cnt==LOCK_WAIT-1 with lock_s==1 -> RELEASE, gap_cnt=0, idx=0.
- RELEASE: gap_cnt increments each cycle; when gap_cnt==GAP_CYCLES-1: rst_n_o[idx] <= 1, idx++, gap_cnt <= 0. Release of idx==NUM_CH-1 moves to RUN on the same edge.
- RUN: all rst_n_o 1, seq_done_o 1.
- Exit to HOLD (rst_n_o all 0 on that edge), checked in RELEASE and RUN, priority high to low:
  - btn_f==0 -> cause 1 (also from WAIT_LOCK)
  - lock_s==0 -> cause 2 (in WAIT_LOCK, lock loss only clears lock_cnt)
  - sw_rst_req_i==1 -> cause 3, honoured only in RUN; ignored in other states
- rst_i overrides all: next edge forces HOLD, all counters 0, rst_cause_o 0.
- rst_cause_o updates only on HOLD entry; sticky otherwise.
- Counters sized $clog2 of their terminal value plus 1; no wrap: each counter is cleared before its terminal value is exceeded.

## Timing
- Reset values: rst_n_o 0, seq_done_o 0, rst_cause_o 0, state_o 0, all counters 0, synchronisers 1 (button) / 0 (lock).
- All outputs registered; no combinational path from inputs to outputs.
- Input sync latency: 2 cycles.
- Channel k releases GAP_CYCLES*(k+1) cycles after RELEASE entry.
- seq_done_o rises on the same edge as the last channel's release.
- Button press seen in RUN: rst_n_o all 0 within 3 cycles of pin edge (no debounce) or 2+DEB_CYCLES+1 cycles (debounce).
- Simultaneous button, lock loss and sw request in RUN: cause 1.

## Configuration
- RST_SEQ_DEBOUNCE_EN defined: btn_f changes only after btn_s differs from btn_f for DEB_CYCLES consecutive cycles; any mismatch-free cycle clears the debounce counter. btn_f resets to 1.
- Not defined: btn_f = btn_s; debounce counter and DEB_CYCLES logic absent.

## Test plan
Bench parameters: NUM_CH=4, GAP_CYCLES=4, LOCK_WAIT=8, DEB_CYCLES=16.
- Power-up: rst_i high 5 cycles, button released, lock high from cycle 0 -> rst_n_o steps 0001,0011,0111,1111 at 4-cycle spacing after WAIT_LOCK completes; seq_done_o 1 with 1111; rst_cause_o 0.
- Lock glitch in WAIT_LOCK: lock low 1 cycle after 5 locked cycles -> lock_cnt restarts; RELEASE entered 8 locked cycles after glitch ends.
- Lock loss in RUN -> rst_n_o 0000 within 3 cycles, rst_cause_o 2, full resequence after lock returns.
- sw_rst_req_i pulse in RUN -> HOLD, cause 3, resequence; same pulse during RELEASE ignored.
- With RST_SEQ_DEBOUNCE_EN: 10-cycle button pulse -> no effect; 20-cycle pulse -> HOLD, cause 1. Without macro: 3-cycle pulse -> HOLD.
- rst_i asserted mid-RELEASE (after 0011) -> next edge rst_n_o 0000, state_o 0, rst_cause_o 0.
